// File: rtl/pair_entry_fifo.sv
// pair_entry_fifo: host-to-pipeline pair injector; FIFO plus 16-slot frame pacing (optional parity: PAIR_ENTRY_PARITY_EN)
module pair_entry_fifo #(
  parameter int DEPTH     = 64,
  parameter int PAYLOAD_W = 192,
  parameter int REC_W     = 227
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PAYLOAD_W-1:0]   host_data,
  input  logic                   host_last,
  input  logic                   write_ctrl,
  input  logic                   stall,
  output logic [REC_W-1:0]       out,
  output logic                   frame_start,
  output logic                   qfull,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int SEQ_W = REC_W - PAYLOAD_W - 4;
  localparam int HALF = PAYLOAD_W / 2;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [REC_W-1:0] NULL_REC = {{SEQ_W{1'b0}}, 2'b11, 2'b00, {PAYLOAD_W{1'b0}}};
  logic [PAYLOAD_W:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic [SEQ_W-1:0] seq;
  logic [3:0] c;
  logic host_read_d;
  logic [PAYLOAD_W:0] head;
  logic [1:0] par;
  logic wr_edge, push, pop;
  assign count = wptr - rptr;
  assign qfull = count == FULL;
  assign wr_edge = write_ctrl && !host_read_d;
  assign push = wr_edge && !qfull;
  assign pop = !stall && c < 4'd14 && count != '0;
  assign head = mem[rptr[AW-1:0]];
`ifdef PAIR_ENTRY_PARITY_EN
  assign par = {^head[PAYLOAD_W-1:HALF], ^head[HALF-1:0]};
`else
  assign par = 2'b00;
`endif
  // FIFO storage: tail written on an accepted host edge
  always_ff @(posedge clk)
    if (push) mem[wptr[AW-1:0]] <= {host_last, host_data};
  // pointers, frame pacing, sequence and the registered output record
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      seq <= '0;
      c <= 4'd15;
      host_read_d <= 1'b0;
      out <= NULL_REC;
      frame_start <= 1'b0;
      overflow <= 1'b0;
    end else begin
      host_read_d <= write_ctrl;
      if (push) wptr <= wptr + 1'b1;
      if (wr_edge && qfull) overflow <= 1'b1;
      if (!stall) c <= c + 4'd1;
      frame_start <= !stall && c == 4'd0;
      out <= pop ? {seq, head[PAYLOAD_W] ? 2'b10 : 2'b01, par, head[PAYLOAD_W-1:0]} : NULL_REC;
      if (pop) begin
        rptr <= rptr + 1'b1;
        seq <= seq + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pair_entry_fifo.sv
// tb_pair_entry_fifo: randomized scoreboard bench against a queue-based frame model
module tb_pair_entry_fifo;
  localparam int DEPTH = 64;
  localparam logic [226:0] NULL_REC = {31'd0, 2'b11, 194'd0};
  typedef struct packed {
    logic [226:0] o;
    logic fs, qf, ov;
    logic [6:0] cnt;
  } exp_t;
  logic clk = 1'b0, reset, write_ctrl, host_last, stall;
  logic [191:0] host_data;
  logic [226:0] out;
  logic frame_start, qfull, overflow;
  logic [6:0] count;
  int total = 0, passed = 0;
  exp_t expq[$];
  logic [192:0] mq[$];
  int mc = 15;
  logic [30:0] mseq = '0;
  logic mprev = 1'b0, movf = 1'b0;

  pair_entry_fifo #(.DEPTH(DEPTH), .PAYLOAD_W(192), .REC_W(227)) dut (
    .clk(clk), .reset(reset), .host_data(host_data), .host_last(host_last),
    .write_ctrl(write_ctrl), .stall(stall), .out(out), .frame_start(frame_start),
    .qfull(qfull), .overflow(overflow), .count(count));

  always #5 clk = ~clk;

  function automatic logic [1:0] par(input logic [191:0] p);
`ifdef PAIR_ENTRY_PARITY_EN
    return {^p[191:96], ^p[95:0]};
`else
    return 2'b00;
`endif
  endfunction

  task automatic chk(input string nm, input logic [226:0] act, input logic [226:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
  endtask

  // reference model: a plain queue, a slot number and a sequence number, one step per edge
  always @(posedge clk) begin
    exp_t e;
    logic [192:0] h;
    int n;
    e.o = NULL_REC;
    e.fs = 1'b0;
    if (!reset) begin
      mq.delete();
      mc = 15;
      mseq = '0;
      mprev = 1'b0;
      movf = 1'b0;
    end else begin
      n = mq.size();
      if (!stall && mc < 14 && n > 0) begin
        h = mq.pop_front();
        e.o = {mseq, h[192] ? 2'b10 : 2'b01, par(h[191:0]), h[191:0]};
        mseq++;
      end
      if (write_ctrl && !mprev) begin
        if (n == DEPTH) movf = 1'b1;
        else mq.push_back({host_last, host_data});
      end
      e.fs = !stall && mc == 0;
      if (!stall) mc = (mc + 1) % 16;
      mprev = write_ctrl;
    end
    e.ov = movf;
    e.cnt = 7'(mq.size());
    e.qf = mq.size() == DEPTH;
    expq.push_back(e);
  end

  // monitor: compares the registered outputs a little after every edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expq.size() == 0) begin
      total++;
      $display("FAIL scoreboard: got empty queue expected an entry at %0t", $time);
    end else begin
      e = expq.pop_front();
      chk("out", out, e.o);
      chk("frame_start", 227'(frame_start), 227'(e.fs));
      chk("qfull", 227'(qfull), 227'(e.qf));
      chk("overflow", 227'(overflow), 227'(e.ov));
      chk("count", 227'(count), 227'(e.cnt));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic l);
    @(negedge clk);
    write_ctrl = 1'b1;
    host_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    host_last = l;
    @(negedge clk);
    write_ctrl = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    write_ctrl = 1'b0;
    host_last = 1'b0;
    stall = 1'b0;
    host_data = '0;
    cyc(3);
    reset = 1'b1;
    cyc(40);
    wr(1'b0); wr(1'b0); wr(1'b1);
    cyc(40);
    for (int i = 0; i < 20; i++) wr(1'(i % 5 == 4));
    cyc(60);
    stall = 1'b1;
    for (int i = 0; i < 65; i++) wr(1'($urandom_range(0, 1)));
    cyc(2);
    stall = 1'b0;
    cyc(100);
    stall = 1'b1;
    for (int i = 0; i < 10; i++) wr(1'b0);
    stall = 1'b0;
    for (int i = 0; i < 32 && mc != 5; i++) cyc(1);
    stall = 1'b1;
    cyc(3);
    stall = 1'b0;
    cyc(40);
    write_ctrl = 1'b1;
    cyc(10);
    write_ctrl = 1'b0;
    cyc(2);
    write_ctrl = 1'b1;
    cyc(3);
    write_ctrl = 1'b0;
    cyc(40);
    stall = 1'b1;
    for (int i = 0; i < 8; i++) wr(1'b0);
    stall = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(30);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      write_ctrl = 1'($urandom_range(0, 1));
      host_last = 1'($urandom_range(0, 1));
      host_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      stall = (i % 600) < 200 ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
    end
    write_ctrl = 1'b0;
    stall = 1'b0;
    cyc(200);
    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
